commit_trace_tx: RTL and testbench
==================================

COMMIT_TRACE_TX -- requirements
Module: commit_trace_tx

Interface
REQ-001 Parameter DEPTH, default 8, trace FIFO entries; SHALL be a power of two, >= 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 wb_valid  input  1  one instruction retires at writeback this cycle.
REQ-005 wb_pc  input  64  PC of retiring instruction.
REQ-006 wb_inst  input  32  encoding of retiring instruction.
REQ-007 wb_a0  input  64  current value of GPR x10 (a0).
REQ-008 wb_unknown  input  1  retiring instruction failed decode.
REQ-009 wb_stall  output  1  backpressure to core; core SHALL hold the WB inputs while high.
REQ-010 tr_valid  output  1  trace entry available to host reader.
REQ-011 tr_ready  input  1  host accepts the entry.
REQ-012 tr_pc  output  64  PC of head entry.
REQ-013 tr_inst  output  32  instruction of head entry.
REQ-014 halt  output  1  simulation-end request, sticky.
REQ-015 halt_cause  output  2  0 none, 1 ebreak, 2 unknown instruction.
REQ-016 halt_code  output  64  exit code reported with halt.
REQ-017 retired_cnt  output  64  accepted retirements since reset.

Function
REQ-018 Retire accept: wb_valid && !wb_stall; only accepted retirements are pushed, counted, or inspected for halt.
REQ-019 FIFO: circular buffer of DEPTH {pc,inst}; pointers wrap modulo DEPTH; occupancy count 0..DEPTH.
REQ-020 Pop: tr_valid && tr_ready; tr_valid = (count != 0); tr_pc/tr_inst SHALL hold the head entry and remain stable while tr_valid && !tr_ready.
REQ-021 Latency: an entry pushed at edge N is visible on tr_valid/tr_pc/tr_inst after edge N (one cycle), when FIFO was empty.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-023 wb_stall = (count == DEPTH) || (state != RUN); no push when full, even if a pop occurs that cycle.
REQ-024 FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-025 RUN -> DRAIN on accepted retire with wb_inst == 32'h00100073: entry still pushed; halt_cause <= 1, halt_code <= wb_a0 of that cycle.
REQ-026 RUN -> DRAIN on accepted retire with wb_unknown=1 (not ebreak): entry pushed; halt_cause <= 2, halt_code <= 64'hFFFF_FFFF_FFFF_FFFF.
REQ-027 Ebreak encoding together with wb_unknown=1: ebreak takes priority (cause 1).
REQ-028 DRAIN: wb_valid ignored; pops continue; DRAIN -> HALTED on the edge where count becomes 0 (final pop) or immediately if count is already 0.
REQ-029 HALTED: halt=1, wb_stall=1, tr_valid=0; state, halt_cause and halt_code held until reset.
REQ-030 halt = (state == HALTED); halt_cause/halt_code are 0 in RUN and latched values in DRAIN/HALTED.
REQ-031 retired_cnt increments by 1 per accepted retire, including the halting instruction; wraps modulo 2^64.
REQ-032 wb_valid with wb_stall high SHALL have no effect on any state.

Reset
REQ-033 rst_n low SHALL immediately, regardless of clk: count=0, pointers=0, state=RUN, tr_valid=0, wb_stall=0, halt=0, halt_cause=0, halt_code=0, retired_cnt=0.
REQ-034 Reset asserted mid-DRAIN or while FIFO non-empty SHALL discard all entries; no partial entry appears after release.
REQ-035 First push allowed on the first rising edge after rst_n deasserts.

Verification
REQ-036 tr_ready=1, retire pc=0x80000000 inst=0x00000413 -> next cycle tr_valid=1, tr_pc=0x80000000, tr_inst=0x00000413; retired_cnt=1.
REQ-037 tr_ready=0, 8 retires with DEPTH=8 -> wb_stall=1 after 8th; 9th wb_valid ignored; raising tr_ready pops 8 entries in push order, no loss/duplication.
REQ-038 Full FIFO, wb_valid=1 and tr_ready=1 same cycle -> pop only, count 8->7, wb_stall drops next cycle.
REQ-039 3 entries queued, retire inst=0x00100073 with wb_a0=0x0 -> wb_stall=1, 4 entries drain, halt=1 one cycle after last pop, halt_cause=1, halt_code=0; later wb_valid ignored.
REQ-040 Retire with wb_unknown=1, wb_a0=0x5 -> halt_cause=2, halt_code=all ones after drain; ebreak with wb_unknown=1 -> halt_cause=1.
REQ-041 rst_n pulsed low between clock edges during DRAIN with 2 entries -> all outputs zero immediately; after release state=RUN, tr_valid=0.

Source files
------------

// File: rtl/commit_trace_tx.sv
// Commit trace transmitter: buffers retired {pc,inst} pairs for a host reader and
// turns ebreak / undecodable instructions into a sticky, drained halt request.
module commit_trace_tx #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [63:0] wb_pc,
  input  logic [31:0] wb_inst,
  input  logic [63:0] wb_a0,
  input  logic        wb_unknown,
  output logic        wb_stall,
  output logic        tr_valid,
  input  logic        tr_ready,
  output logic [63:0] tr_pc,
  output logic [31:0] tr_inst,
  output logic        halt,
  output logic [1:0]  halt_cause,
  output logic [63:0] halt_code,
  output logic [63:0] retired_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [31:0]  EBREAK   = 32'h0010_0073;
  localparam logic [1:0]   CAUSE_NONE    = 2'd0;
  localparam logic [1:0]   CAUSE_EBREAK  = 2'd1;
  localparam logic [1:0]   CAUSE_UNKNOWN = 2'd2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    cause_q, cause_d;
  logic [63:0]   code_q, code_d;
  logic [63:0]   retired_q, retired_d;

  logic [63:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];

  logic push, pop;

  assign wb_stall    = (count_q == CNT_FULL) || (state_q != RUN);
  assign tr_valid    = (count_q != '0) && (state_q != HALTED);
  assign push        = wb_valid && !wb_stall;
  assign pop         = tr_valid && tr_ready;
  assign tr_pc       = mem_pc[rd_ptr_q];
  assign tr_inst     = mem_inst[rd_ptr_q];
  assign halt        = (state_q == HALTED);
  assign halt_cause  = cause_q;
  assign halt_code   = code_q;
  assign retired_cnt = retired_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    cause_d   = cause_q;
    code_d    = code_q;
    retired_d = retired_q;

    if (push) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      retired_d = retired_q + 64'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case (state_q)
      RUN: begin
        // Ebreak is checked first so it wins over a simultaneous decode failure.
        if (push && (wb_inst == EBREAK)) begin
          state_d = DRAIN;
          cause_d = CAUSE_EBREAK;
          code_d  = wb_a0;
        end else if (push && wb_unknown) begin
          state_d = DRAIN;
          cause_d = CAUSE_UNKNOWN;
          code_d  = '1;
        end
      end
      DRAIN: begin
        if (count_d == '0) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
        cause_d = CAUSE_NONE;
        code_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cause_q   <= CAUSE_NONE;
      code_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cause_q   <= cause_d;
      code_q    <= code_d;
      retired_q <= retired_d;
    end
  end

  // Payload storage is never read while count is zero, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]   <= wb_pc;
      mem_inst[wr_ptr_q] <= wb_inst;
    end
  end

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed bench for commit_trace_tx: expected trace entries go into a queue and
// a negedge monitor checks every handshaked entry against it.
module tb_commit_trace_tx;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [63:0] wb_pc;
  logic [31:0] wb_inst;
  logic [63:0] wb_a0;
  logic        wb_unknown;
  logic        wb_stall;
  logic        tr_valid;
  logic        tr_ready;
  logic [63:0] tr_pc;
  logic [31:0] tr_inst;
  logic        halt;
  logic [1:0]  halt_cause;
  logic [63:0] halt_code;
  logic [63:0] retired_cnt;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  commit_trace_tx #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_a0(wb_a0),
    .wb_unknown(wb_unknown), .wb_stall(wb_stall),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_inst(tr_inst),
    .halt(halt), .halt_cause(halt_cause), .halt_code(halt_code),
    .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at negedge completes at the following posedge.
  always @(negedge clk) begin
    if (rst_n && tr_valid && tr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL trace_unexpected: got pc=%h inst=%h, expected no entry", tr_pc, tr_inst);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("trace_pc", tr_pc, e.pc);
        chk("trace_inst", {32'd0, tr_inst}, {32'd0, e.inst});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [63:0] pc, input logic [31:0] inst,
                        input logic [63:0] a0, input logic unk, input bit accept);
    wb_valid   = 1'b1;
    wb_pc      = pc;
    wb_inst    = inst;
    wb_a0      = a0;
    wb_unknown = unk;
    if (accept) exp_q.push_back('{pc: pc, inst: inst});
    tick();
    wb_valid   = 1'b0;
    wb_unknown = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_inst = '0; wb_a0 = '0;
    wb_unknown = 1'b0; tr_ready = 1'b0;
    #3;
    chk("rst_tr_valid", {63'd0, tr_valid}, 64'd0);
    chk("rst_wb_stall", {63'd0, wb_stall}, 64'd0);
    chk("rst_halt", {63'd0, halt}, 64'd0);
    chk("rst_retired", retired_cnt, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single retire, one-cycle visibility
    tr_ready = 1'b1;
    retire(64'h8000_0000, 32'h0000_0413, 64'd0, 1'b0, 1'b1);
    chk("lat_tr_valid", {63'd0, tr_valid}, 64'd1);
    chk("lat_retired", retired_cnt, 64'd1);
    tick();
    tr_ready = 1'b0;
    chk("lat_empty_after_pop", {63'd0, tr_valid}, 64'd0);

    // Fill to DEPTH, overflow attempt ignored
    for (int i = 0; i < 8; i++)
      retire(64'h1000 + 64'(i * 4), 32'h0000_0013 + 32'(i << 7), 64'd0, 1'b0, 1'b1);
    chk("full_stall", {63'd0, wb_stall}, 64'd1);
    wb_valid = 1'b1; wb_pc = 64'hDEAD; wb_inst = 32'h0000_0033;
    tick();
    chk("full_retired", retired_cnt, 64'd9);
    chk("full_still_stall", {63'd0, wb_stall}, 64'd1);

    // Full with push and pop in the same cycle: only the pop happens
    tr_ready = 1'b1;
    tick();
    wb_valid = 1'b0;
    chk("full_pop_stall_drop", {63'd0, wb_stall}, 64'd0);
    chk("full_pop_retired", retired_cnt, 64'd9);
    for (int i = 0; i < 7; i++) tick();
    chk("drain8_empty", {63'd0, tr_valid}, 64'd0);
    chk("drain8_queue", 64'(exp_q.size()), 64'd0);
    tr_ready = 1'b0;

    // Ebreak with three queued entries
    retire(64'h2000, 32'h0000_0093, 64'd0, 1'b0, 1'b1);
    retire(64'h2004, 32'h0000_0113, 64'd0, 1'b0, 1'b1);
    retire(64'h2008, 32'h0000_0193, 64'd0, 1'b0, 1'b1);
    retire(64'h200C, 32'h0010_0073, 64'd0, 1'b0, 1'b1);
    chk("ebr_stall", {63'd0, wb_stall}, 64'd1);
    chk("ebr_halt_early", {63'd0, halt}, 64'd0);
    chk("ebr_cause_drain", {62'd0, halt_cause}, 64'd1);
    chk("ebr_retired", retired_cnt, 64'd13);
    wb_valid = 1'b1; wb_pc = 64'hBAD0; wb_inst = 32'h0000_0013;
    tr_ready = 1'b1;
    tick(); tick(); tick();
    chk("ebr_halt_before_last", {63'd0, halt}, 64'd0);
    tick();
    chk("ebr_halt", {63'd0, halt}, 64'd1);
    chk("ebr_cause", {62'd0, halt_cause}, 64'd1);
    chk("ebr_code", halt_code, 64'd0);
    chk("ebr_tr_valid", {63'd0, tr_valid}, 64'd0);
    tick();
    chk("ebr_ignored_retired", retired_cnt, 64'd13);
    chk("ebr_halt_sticky", {63'd0, halt}, 64'd1);
    wb_valid = 1'b0;
    chk("ebr_queue", 64'(exp_q.size()), 64'd0);

    // Unknown instruction halt
    do_reset();
    tr_ready = 1'b1;
    retire(64'h3000, 32'hFFFF_FFFF, 64'h5, 1'b1, 1'b1);
    chk("unk_cause_drain", {62'd0, halt_cause}, 64'd2);
    tick();
    chk("unk_halt", {63'd0, halt}, 64'd1);
    chk("unk_cause", {62'd0, halt_cause}, 64'd2);
    chk("unk_code", halt_code, 64'hFFFF_FFFF_FFFF_FFFF);

    // Ebreak flagged unknown: ebreak wins
    do_reset();
    retire(64'h3100, 32'h0010_0073, 64'h77, 1'b1, 1'b1);
    tick();
    chk("prio_halt", {63'd0, halt}, 64'd1);
    chk("prio_cause", {62'd0, halt_cause}, 64'd1);
    chk("prio_code", halt_code, 64'h77);

    // Asynchronous reset mid-DRAIN with two entries held
    do_reset();
    tr_ready = 1'b0;
    retire(64'h4000, 32'h0000_0513, 64'd0, 1'b0, 1'b1);
    retire(64'h4004, 32'h0010_0073, 64'h9, 1'b0, 1'b1);
    chk("ar_pre_valid", {63'd0, tr_valid}, 64'd1);
    chk("ar_pre_stall", {63'd0, wb_stall}, 64'd1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("ar_tr_valid", {63'd0, tr_valid}, 64'd0);
    chk("ar_wb_stall", {63'd0, wb_stall}, 64'd0);
    chk("ar_cause", {62'd0, halt_cause}, 64'd0);
    chk("ar_code", halt_code, 64'd0);
    chk("ar_retired", retired_cnt, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("ar_post_valid", {63'd0, tr_valid}, 64'd0);
    chk("ar_post_halt", {63'd0, halt}, 64'd0);

    // First retire right after release is accepted
    tr_ready = 1'b1;
    retire(64'h5000, 32'h0000_0793, 64'd0, 1'b0, 1'b1);
    chk("post_retired", retired_cnt, 64'd1);
    chk("post_valid", {63'd0, tr_valid}, 64'd1);
    tick();
    chk("post_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
